// File: rtl/serial_add_ctrl_if.sv
// Request/response bundle between a requesting unit and the bit-serial adder controller.
// Handshake: an operation is accepted on a rising edge where start && ready; done pulses
// for one cycle when result/cout/overflow become valid, and they hold until the next done.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, op_a, op_b, cin_in,
    input  ready, busy, done, result, cout, overflow
  );

  modport slave (
    input  start, sub, op_a, op_b, cin_in,
    output ready, busy, done, result, cout, overflow
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: one shared full adder is stepped over WIDTH cycles,
// LSB first, with the running carry held in a flop.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_add_ctrl_if.slave  bus,
  output logic [1:0]        dbg_state
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic             c_msb_q, c_msb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // A's shift register doubles as the accumulator: each sum bit enters at the MSB as the
  // consumed operand bit leaves at the LSB, so after WIDTH steps it holds the full result.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.op_a;
          b_sh_d  = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub ? 1'b1 : bus.cin_in;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = {fa_sum, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 2)) begin
          c_msb_d = fa_cout;
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Final bit: publish outputs so they are valid on entry to DONE.
          result_d = {fa_sum, a_sh_q[WIDTH-1:1]};
          cout_d   = fa_cout;
          ovf_d    = c_msb_q ^ fa_cout;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: a vector table plus hand-written sequences for
// ignored starts, asynchronous reset mid-run and back-to-back operation.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t         vecs[8];
  vec_t         held[3];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_start", 32'(bus.ready), 32'd1);
  endtask

  // Driver: issue one operation, track latency, score result when done arrives.
  task automatic run_op(input vec_t v, input string tag);
    int           lat;
    bit           seen;
    logic [W-1:0] exp;
    wait_ready();
    bus.start  = 1'b1;
    bus.sub    = v.sub;
    bus.op_a   = v.a;
    bus.op_b   = v.b;
    bus.cin_in = v.cin;
    exp_q.push_back(v.res);
    @(posedge clk);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
      if (bus.done) seen = 1;
      else check({tag, "_busy"}, {30'd0, bus.busy, bus.ready}, 32'd2);
    end
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    if (seen) begin
      exp = exp_q.pop_front();
      check({tag, "_result"}, 32'(bus.result), 32'(exp));
      check({tag, "_cout"}, 32'(bus.cout), 32'(v.co));
      check({tag, "_ovf"}, 32'(bus.overflow), 32'(v.ov));
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'd0, bus.done, bus.ready}, 32'd1);
      check({tag, "_result_hold"}, 32'(bus.result), 32'(exp));
    end else begin
      void'(exp_q.pop_front());
      check({tag, "_done_timeout"}, 32'd0, 32'd1);
    end
  endtask

  initial begin : main
    int  lat;
    int  k;
    int  done_cnt;
    int  pulse_cyc[3];
    bit  seen;

    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0};

    held[0] = '{1'b0, 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0};
    held[1] = '{1'b0, 8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    held[2] = '{1'b1, 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.sub    = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.cin_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
    check("reset_outputs", {22'd0, bus.result, bus.cout, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(bus.ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Re-pulsed start during RUN must be ignored
    wait_ready();
    bus.start = 1'b1; bus.sub = 1'b0; bus.op_a = 8'h5A; bus.op_b = 8'h3C; bus.cin_in = 1'b0;
    @(posedge clk);
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      check("ign_ready_low", 32'(bus.ready), 32'd0);
      if (bus.done) begin
        seen = 1;
        bus.start = 1'b0;
      end else begin
        bus.start = 1'b1; bus.op_a = 8'h01; bus.op_b = 8'h01;
      end
    end
    check("ign_latency", 32'(lat), 32'(W + 1));
    check("ign_result", 32'(bus.result), 32'h96);
    @(negedge clk);
    check("ign_idle", {30'd0, bus.ready, bus.busy}, 32'd2);
    @(negedge clk);
    check("ign_no_accept", {30'd0, bus.ready, bus.busy}, 32'd2);

    // Asynchronous reset in the middle of RUN
    bus.start = 1'b1; bus.op_a = 8'h5A; bus.op_b = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_flags", {29'd0, bus.ready, bus.busy, bus.done}, 32'd4);
    check("arst_outputs", {22'd0, bus.result, bus.cout, bus.overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);
    run_op('{1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0}, "after_rst");

    // start held high across three operations
    wait_ready();
    bus.start = 1'b1; bus.sub = held[0].sub; bus.op_a = held[0].a;
    bus.op_b = held[0].b; bus.cin_in = held[0].cin;
    k = 0; lat = 0;
    while (k < 3 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.done) begin
        pulse_cyc[k] = cyc;
        check($sformatf("held%0d_result", k), 32'(bus.result), 32'(held[k].res));
        check($sformatf("held%0d_cout", k), 32'(bus.cout), 32'(held[k].co));
        check($sformatf("held%0d_ovf", k), 32'(bus.overflow), 32'(held[k].ov));
        k++;
        if (k < 3) begin
          bus.sub = held[k].sub; bus.op_a = held[k].a;
          bus.op_b = held[k].b; bus.cin_in = held[k].cin;
        end else begin
          bus.start = 1'b0;
        end
      end else if (k > 0) begin
        check("held_stable", 32'(bus.result), 32'(held[k-1].res));
      end
    end
    check("held_pulses", 32'(k), 32'd3);
    if (k == 3) begin
      check("held_gap01", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(W + 2));
      check("held_gap12", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'(W + 2));
    end
    bus.start = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end
endmodule
